// File: rtl/serdes_word_aligner_pkg.sv
// Shared definitions for the SERDES word aligner: FSM state encoding and
// a helper that sizes saturating counters.
package serdes_word_aligner_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    // Bits needed to hold a counter that runs 0..max_val inclusive.
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serdes_sync_detect.sv
// Serial-to-window shifter with fill tracking; flags the sync pattern once
// a full word's worth of fresh bits has been collected.
module serdes_sync_detect
    import serdes_word_aligner_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(8'hBC),
    parameter bit                    MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] win_next,
    output logic                  match
);

    localparam int unsigned FW = cnt_bits(DATA_WIDTH);
    localparam logic [FW-1:0] FILL_MAX = FW'(DATA_WIDTH);
    localparam logic [FW-1:0] FILL_PRE = FW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] win;
    logic [FW-1:0]         fill;

    // The bit being shifted in this cycle counts toward the fill, so the
    // window is complete once W-1 earlier bits are already held.
    always_comb begin
        if (MSB_FIRST) begin
            win_next = {win[DATA_WIDTH-2:0], serial_in};
        end else begin
            win_next = {serial_in, win[DATA_WIDTH-1:1]};
        end
        match = (fill >= FILL_PRE) && (win_next == SYNC_WORD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win  <= '0;
            fill <= '0;
        end else if (clear) begin
            win  <= '0;
            fill <= '0;
        end else if (enable) begin
            win <= win_next;
            if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
        end
    end

endmodule

// File: rtl/serdes_word_aligner.sv
// Hunts for a periodic sync word in a recovered bitstream, verifies it over
// several frames, then emits aligned words with frame markers.
module serdes_word_aligner
    import serdes_word_aligner_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(8'hBC),
    parameter int                    FRAME_LEN    = 4,
    parameter bit                    MSB_FIRST    = 1'b1,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  resync,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  frame_start,
    output logic                  sync_err,
    output logic                  locked,
    output logic [1:0]            state
);

    localparam int unsigned PW = $clog2(DATA_WIDTH);
    localparam int unsigned SW = $clog2(FRAME_LEN);
    localparam int unsigned GW = cnt_bits(LOCK_COUNT);
    localparam int unsigned MW = cnt_bits(UNLOCK_COUNT);

    localparam logic [PW-1:0] LAST_PHASE = PW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] LOCK_TC    = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] UNLOCK_TC  = MW'(UNLOCK_COUNT);

    logic [DATA_WIDTH-1:0] win_next;
    logic                  match;

    align_state_t          state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [GW-1:0]         good_q, good_d, good_inc;
    logic [MW-1:0]         miss_q, miss_d, miss_inc;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  valid_d, fs_d, err_d;
    logic                  boundary;

    serdes_sync_detect #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_WORD  (SYNC_WORD),
        .MSB_FIRST  (MSB_FIRST)
    ) u_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (resync),
        .serial_in (serial_in),
        .win_next  (win_next),
        .match     (match)
    );

    assign boundary = (phase_q == LAST_PHASE);
    assign good_inc = good_q + GW'(1);
    assign miss_inc = miss_q + MW'(1);

    // Next-state, counters and output pulses; every decision is taken on an
    // enabled bit, and resync overrides everything including enable.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        good_d  = good_q;
        miss_d  = miss_q;
        word_d  = word_out;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        err_d   = 1'b0;

        if (resync) begin
            state_d = ST_HUNT;
            phase_d = '0;
            slot_d  = '0;
            good_d  = '0;
            miss_d  = '0;
        end else if (enable) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        phase_d = '0;
                        slot_d  = SW'(1);
                        good_d  = GW'(1);
                        miss_d  = '0;
                        state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY, ST_LOCKED: begin
                    phase_d = boundary ? '0 : phase_q + PW'(1);
                    if (boundary) begin
                        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
                        if (state_q == ST_LOCKED) begin
                            valid_d = 1'b1;
                            word_d  = win_next;
                            fs_d    = (slot_q == '0);
                        end
                        if (slot_q == '0) begin
                            if (state_q == ST_VERIFY) begin
                                if (match) begin
                                    good_d = good_inc;
                                    if (good_inc == LOCK_TC) begin
                                        state_d = ST_LOCKED;
                                        miss_d  = '0;
                                    end
                                end else begin
                                    state_d = ST_HUNT;
                                    phase_d = '0;
                                    slot_d  = '0;
                                    good_d  = '0;
                                    miss_d  = '0;
                                end
                            end else if (match) begin
                                miss_d = '0;
                            end else begin
                                err_d  = 1'b1;
                                miss_d = miss_inc;
                                if (miss_inc == UNLOCK_TC) begin
                                    state_d = ST_HUNT;
                                    phase_d = '0;
                                    slot_d  = '0;
                                    good_d  = '0;
                                    miss_d  = '0;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            phase_q     <= '0;
            slot_q      <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            word_out    <= word_d;
            word_valid  <= valid_d;
            frame_start <= fs_d;
            sync_err    <= err_d;
            locked      <= (state_d == ST_LOCKED);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Drives an MSB-first and an LSB-first aligner with the same word stream and
// checks both every cycle against a frame-level reference model.
module tb_serdes_word_aligner;

    localparam int        W    = 8;
    localparam int        FL   = 4;
    localparam int        LOCK = 3;
    localparam int        UNLK = 4;
    localparam logic [7:0] SYNC = 8'hBC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       resync;
    logic [1:0] ser;

    logic [7:0] wo [2];
    logic       wv [2];
    logic       fs [2];
    logic       se [2];
    logic       lk [2];
    logic [1:0] st [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int gap_pct = 0;

    // Reference model: 0 = msb instance, 1 = lsb instance.
    int m_win [2], m_nbits [2], m_phase [2], m_slot [2];
    int m_good [2], m_miss [2], m_mode [2];
    int e_word [2], e_valid [2], e_fs [2], e_err [2];

    always #5 clk = ~clk;

    serdes_word_aligner #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .resync(resync),
        .serial_in(ser[0]), .word_out(wo[0]), .word_valid(wv[0]),
        .frame_start(fs[0]), .sync_err(se[0]), .locked(lk[0]), .state(st[0])
    );

    serdes_word_aligner #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .resync(resync),
        .serial_in(ser[1]), .word_out(wo[1]), .word_valid(wv[1]),
        .frame_start(fs[1]), .sync_err(se[1]), .locked(lk[1]), .state(st[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear(input int i);
        m_phase[i] = 0;
        m_slot[i]  = 0;
        m_good[i]  = 0;
        m_miss[i]  = 0;
        m_mode[i]  = 0;
    endtask

    task automatic modelReset(input int i);
        modelClear(i);
        m_win[i]   = 0;
        m_nbits[i] = 0;
        e_word[i]  = 0;
        e_valid[i] = 0;
        e_fs[i]    = 0;
        e_err[i]   = 0;
    endtask

    task automatic modelStep(input int i, input bit en, input bit rs, input bit b);
        int  slot_now;
        bit  is_sync;
        e_valid[i] = 0;
        e_fs[i]    = 0;
        e_err[i]   = 0;
        if (rs) begin
            modelClear(i);
            m_win[i]   = 0;
            m_nbits[i] = 0;
            return;
        end
        if (!en) return;
        if (i == 0) m_win[i] = (m_win[i] * 2 + int'(b)) % 256;
        else        m_win[i] = m_win[i] / 2 + int'(b) * 128;
        m_nbits[i]++;
        is_sync = (m_nbits[i] >= W) && (m_win[i] == int'(SYNC));
        if (m_mode[i] == 0) begin
            if (is_sync) begin
                m_phase[i] = 0;
                m_slot[i]  = 1;
                m_good[i]  = 1;
                m_miss[i]  = 0;
                m_mode[i]  = (LOCK == 1) ? 2 : 1;
            end
            return;
        end
        if (m_phase[i] != W - 1) begin
            m_phase[i]++;
            return;
        end
        m_phase[i] = 0;
        slot_now   = m_slot[i];
        m_slot[i]  = (m_slot[i] + 1) % FL;
        if (m_mode[i] == 2) begin
            e_valid[i] = 1;
            e_word[i]  = m_win[i];
            e_fs[i]    = (slot_now == 0) ? 1 : 0;
        end
        if (slot_now != 0) return;
        if (m_mode[i] == 1) begin
            if (is_sync) begin
                m_good[i]++;
                if (m_good[i] == LOCK) begin
                    m_mode[i] = 2;
                    m_miss[i] = 0;
                end
            end else begin
                modelClear(i);
            end
        end else if (is_sync) begin
            m_miss[i] = 0;
        end else begin
            e_err[i] = 1;
            m_miss[i]++;
            if (m_miss[i] == UNLK) modelClear(i);
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 2; i++) begin
            string nm;
            nm = (i == 0) ? "msb" : "lsb";
            checkOutput({nm, ".word_valid"},  32'(wv[i]), 32'(e_valid[i]));
            checkOutput({nm, ".frame_start"}, 32'(fs[i]), 32'(e_fs[i]));
            checkOutput({nm, ".sync_err"},    32'(se[i]), 32'(e_err[i]));
            checkOutput({nm, ".word_out"},    32'(wo[i]), e_word[i]);
            checkOutput({nm, ".locked"},      32'(lk[i]), (m_mode[i] == 2) ? 32'd1 : 32'd0);
            checkOutput({nm, ".state"},       32'(st[i]), m_mode[i]);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit rs, input bit b0, input bit b1);
        @(negedge clk);
        enable = en;
        resync = rs;
        ser    = {b1, b0};
        @(posedge clk);
        modelStep(0, en, rs, b0);
        modelStep(1, en, rs, b1);
        #1;
        compareAll();
    endtask

    task automatic randBit(output bit b);
        b = 1'($urandom_range(1));
    endtask

    task automatic sendBit(input bit b0, input bit b1);
        bit r0, r1;
        while (int'($urandom_range(99)) < gap_pct) begin
            randBit(r0);
            randBit(r1);
            applyStimulus(1'b0, 1'b0, r0, r1);
        end
        applyStimulus(1'b1, 1'b0, b0, b1);
    endtask

    // A word goes out in each instance's own bit order.
    task automatic sendWord(input logic [7:0] w, input int gap_at = -1);
        for (int k = 0; k < W; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < 5; g++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            end
            sendBit(w[7-k], w[k]);
        end
    endtask

    task automatic sendFrame(input logic [7:0] sw);
        sendWord(sw);
        sendWord(8'h11);
        sendWord(8'h22);
        sendWord(8'h33);
    endtask

    task automatic sendJunk(input int n);
        bit r0, r1;
        for (int k = 0; k < n; k++) begin
            randBit(r0);
            randBit(r1);
            sendBit(r0, r1);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset(0);
        modelReset(1);
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic doResync();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        logic [7:0] sw;
        logic [7:0] rw;
        rst_n  = 1'b0;
        enable = 1'b0;
        resync = 1'b0;
        ser    = 2'b00;
        modelReset(0);
        modelReset(1);
        repeat (2) @(negedge clk);
        compareAll();
        rst_n = 1'b1;

        // Seven bits of the sync word, then reset: the eighth bit must not complete a detection.
        sw = SYNC;
        for (int k = 0; k < W - 1; k++) sendBit(sw[7-k], sw[k]);
        doReset();
        sendBit(sw[0], sw[7]);
        checkOutput("no_false_detect.msb", 32'(st[0]), 32'd0);
        checkOutput("no_false_detect.lsb", 32'(st[1]), 32'd0);

        // Acquisition.
        sendJunk(3);
        repeat (5) sendFrame(SYNC);
        checkOutput("acq_locked.msb", 32'(lk[0]), 32'd1);
        checkOutput("acq_locked.lsb", 32'(lk[1]), 32'd1);

        // Three bad syncs keep lock, a fourth drops it.
        repeat (3) sendFrame(8'h3C);
        checkOutput("miss3_locked", 32'(lk[0]), 32'd1);
        sendFrame(8'h3C);
        checkOutput("miss4_unlocked", 32'(lk[0]), 32'd0);
        checkOutput("miss4_hunt", 32'(st[0]), 32'd0);

        // A good sync in between resets the miss count.
        repeat (3) sendFrame(SYNC);
        repeat (3) sendFrame(8'h3C);
        sendFrame(SYNC);
        sendFrame(8'h3C);
        repeat (2) sendFrame(SYNC);
        checkOutput("miss_reset_locked", 32'(lk[0]), 32'd1);

        // Verify failure returns to hunt without any output.
        doResync();
        sendFrame(SYNC);
        sendWord(8'h00);
        checkOutput("verify_fail_hunt", 32'(st[0]), 32'd0);

        // Bit slip while locked, then relock at the new phase.
        repeat (4) sendFrame(SYNC);
        sendJunk(1);
        repeat (9) sendFrame(SYNC);
        checkOutput("slip_relocked.msb", 32'(lk[0]), 32'd1);
        checkOutput("slip_relocked.lsb", 32'(lk[1]), 32'd1);

        // Enable gaps inside words are transparent.
        for (int f = 0; f < 3; f++) begin
            sendWord(SYNC, 3);
            sendWord(8'h11, 6);
            sendWord(8'h22, 1);
            sendWord(8'h33);
        end
        gap_pct = 20;
        repeat (4) sendFrame(SYNC);
        gap_pct = 0;
        checkOutput("gaps_locked", 32'(lk[0]), 32'd1);

        // Resync while locked drops lock on the next cycle.
        doResync();
        checkOutput("resync_unlock", 32'(lk[0]), 32'd0);

        // Random payloads, gaps, occasional bad syncs and resyncs.
        gap_pct = 15;
        for (int f = 0; f < 40; f++) begin
            sw = ($urandom_range(9) == 0) ? 8'(($urandom_range(255))) : SYNC;
            sendWord(sw);
            for (int s = 1; s < FL; s++) begin
                rw = 8'($urandom_range(255));
                sendWord(rw);
            end
            if ($urandom_range(19) == 0) doResync();
        end
        gap_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_word_aligner.md
# serdes_word_aligner

Downstream companion of the parameterized SERDES deserializer in the comms library. It consumes the raw recovered serial bitstream (one bit per enabled clock) and hunts for a periodic sync word to find word boundaries. Once it has locked, it emits aligned parallel words with frame markers. It also tracks loss of alignment and re-hunts automatically, so a downstream framer/FIFO sees only word-aligned data.

## Interface
- DATA_WIDTH, 8, word width in bits (≥2)
- SYNC_WORD, 8'hBC, sync pattern occupying slot 0 of every frame (DATA_WIDTH bits)
- FRAME_LEN, 4, words per frame including the sync word (≥2)
- MSB_FIRST, 1, 1 = first received bit is word MSB, 0 = first bit is LSB
- LOCK_COUNT, 3, consecutive good syncs required to declare lock (≥1)
- UNLOCK_COUNT, 4, consecutive bad syncs while locked that drop lock (≥1)

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  serial_in is sampled on this clock edge; 0 freezes all state
- resync  input  1  synchronous forced return to HUNT
- serial_in  input  1  serial data bit
- word_out  output  DATA_WIDTH  aligned word, valid with word_valid
- word_valid  output  1  one-cycle pulse per output word
- frame_start  output  1  qualifies word_valid: word is slot 0
- sync_err  output  1  one-cycle pulse: slot 0 mismatch while LOCKED
- locked  output  1  high in LOCKED state
- state  output  2  debug: 0 HUNT, 1 VERIFY, 2 LOCKED

## Operation
- Window shift per enabled bit:
  - MSB_FIRST: win_next = {win[W-2:0], serial_in}.
  - LSB first: win_next = {serial_in, win[W-1:1]}.
- fill counter saturates at W. Sync detection is disallowed until W bits have been shifted since reset/resync.
- bit_phase counts 0..W-1. A word boundary is the enabled cycle where bit_phase==W-1; win_next is then the completed word. slot counts 0..FRAME_LEN-1 and advances at each boundary, wrapping to 0.
- HUNT:
  - Each enabled bit (fill complete) compares win_next with SYNC_WORD.
  - On a match: bit_phase←0, slot←1, good_cnt←1.
  - If LOCK_COUNT==1, go to LOCKED; otherwise go to VERIFY.
- VERIFY:
  - Only boundaries with slot==0 are checked; other boundaries produce no output.
  - Match → good_cnt+1. When good_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt←0.
  - Mismatch → HUNT, counters cleared.
- LOCKED:
  - Every boundary produces word_valid with word_out=win_next and frame_start=(slot==0).
  - Slot 0 match → miss_cnt←0.
  - Slot 0 mismatch → sync_err pulse and miss_cnt+1. When miss_cnt reaches UNLOCK_COUNT, go to HUNT. The failing word is still output.
- The word that completes lock is not output. The first output is slot 1 of the same frame.
- resync=1: state←HUNT and win, fill, bit_phase, slot, good_cnt, miss_cnt all cleared. The bit presented in that cycle is dropped. resync has priority over enable.
- enable=0: no state change and no pulses. Gaps anywhere in a word are transparent.
- Counter widths: bit_phase $clog2(W), slot $clog2(FRAME_LEN), good_cnt/miss_cnt $clog2(max+1). No wrap beyond the terminal count.

## Timing
- Reset values:
  - word_out=0, word_valid=0, frame_start=0, sync_err=0, locked=0, state=HUNT.
  - Internal window, fill, bit_phase, slot, good_cnt and miss_cnt all 0.
- All outputs are registered.
- word_valid, frame_start and sync_err assert the cycle after the edge that samples the word's last bit, for exactly one cycle.
- word_out holds its value until the next word_valid.
- locked/state change the cycle after the deciding boundary edge.
- Reset asserted mid-word discards the partial word immediately (async). The first detection after release needs W fresh bits.

## Structure
- Shared comms package holds the state encoding constants (ST_HUNT=0, ST_VERIFY=1, ST_LOCKED=2).
- Natural sub-module: serdes_sync_detect, containing the window shift register, fill counter and comparator, and producing win_next and match.
- The FSM and counters stay in the top.

## Test plan
Defaults for all scenarios: W=8, SYNC=8'hBC, FRAME_LEN=4, LOCK=3, UNLOCK=4, MSB first.
- Reset check: apply reset mid-stream → all outputs 0 and state=0. With 7 bits of BC pattern followed by reset, no false detection.
- Acquisition: send 3 junk bits then frames {BC,11,22,33}×5.
  - State goes HUNT→VERIFY at the first sync and reaches LOCKED at the third sync.
  - First word_valid carries 8'h11 one cycle after its last bit.
  - Subsequent BC outputs have frame_start=1.
- Loss of lock:
  - While locked, send sync=8'h3C for 3 frames → 3 sync_err pulses, locked stays 1.
  - A 4th bad sync → locked=0 and state=HUNT.
  - Alternatively, one good BC after 3 bad syncs resets miss_cnt, and a later single bad sync does not unlock.
- VERIFY failure: send BC, 11, 22, 33, then 8'h00 in slot 0 → return to HUNT with no word_valid ever asserted.
- Bit slip: while locked, insert one extra bit → 4 sync_err pulses, unlock, then relock at the new phase after 3 frames. Output words are correct.
- Gaps and controls:
  - Toggle enable low for 5 cycles inside words → identical word sequence to the gap-free run.
  - resync pulse while locked → locked=0 next cycle.
  - Repeat acquisition with MSB_FIRST=0 and LSB-first stimulus → same words.
